// File: rtl/fwd_prop_engine.sv
// rtl/fwd_prop_engine.sv - one-hidden-layer Q8.8 MLP forward pass, one prediction per sample row
// Optional FP_SATURATE_EN: clamp to the DW signed range when narrowing; otherwise two's-complement wrap.
module fwd_prop_engine #(
  parameter int ROWS    = 100,
  parameter int COLUMNS = 15,
  parameter int HIDDEN  = 10,
  parameter int DW      = 16,
  parameter int FRAC    = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  output logic [$clog2(ROWS*COLUMNS)-1:0]         x_addr,
  input  logic signed [DW-1:0]                    x_data,
  output logic [$clog2(HIDDEN*(COLUMNS+2)+1)-1:0] w_addr,
  input  logic signed [DW-1:0]                    w_data,
  output logic                                    out_we,
  output logic [$clog2(ROWS)-1:0]                 out_addr,
  output logic signed [DW-1:0]                    out_data,
  output logic                                    busy,
  output logic                                    done_fp
);
  localparam int XAW = $clog2(ROWS*COLUMNS);
  localparam int WAW = $clog2(HIDDEN*(COLUMNS+2)+1);
  localparam int OAW = $clog2(ROWS);
  localparam int JW  = $clog2(HIDDEN);
  localparam int KW  = $clog2(((COLUMNS > HIDDEN) ? COLUMNS : HIDDEN) + 1);
  localparam int AW  = 2*DW + 8;

  typedef enum logic [2:0] {
    S_IDLE, S_HMAC, S_HBIAS, S_OMAC, S_OBIAS, S_WRITE, S_DONE
  } state_t;

  state_t                state_q;
  logic [OAW-1:0]        row_q;
  logic [JW-1:0]         j_q;
  logic [JW-1:0]         hk_q;
  logic [KW-1:0]         k_q;
  logic                  mac_v_q;
  logic [XAW-1:0]        x_base_q;
  logic [WAW-1:0]        w_base_q;
  logic signed [AW-1:0]  acc_q;
  logic signed [DW-1:0]  hid_q [HIDDEN];

  logic [XAW-1:0]        x_addr_q;
  logic [WAW-1:0]        w_addr_q;
  logic                  out_we_q;
  logic [OAW-1:0]        out_addr_q;
  logic signed [DW-1:0]  out_data_q;
  logic                  busy_q;
  logic                  done_q;

  logic signed [DW-1:0]   mul_a_d;
  logic signed [2*DW-1:0] prod_d;
  logic signed [AW-1:0]   bias_d;
  logic signed [AW-1:0]   sum_d;
  logic signed [AW-1:0]   shift_d;
  logic signed [DW-1:0]   narrow_d;
  logic signed [DW-1:0]   relu_d;

  // One shared multiplier: features during hidden MACs, stored h[] during output MACs.
  always_comb begin
    mul_a_d  = (state_q == S_OMAC) ? hid_q[hk_q] : x_data;
    prod_d   = {{DW{mul_a_d[DW-1]}}, mul_a_d} * {{DW{w_data[DW-1]}}, w_data};
    bias_d   = {{(AW-DW-FRAC){w_data[DW-1]}}, w_data, {FRAC{1'b0}}};
    sum_d    = acc_q + bias_d;
    shift_d  = sum_d >>> FRAC;
    narrow_d = shift_d[DW-1:0];
`ifdef FP_SATURATE_EN
    if (shift_d[AW-1:DW-1] != {(AW-DW+1){shift_d[AW-1]}})
      narrow_d = shift_d[AW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`endif
    relu_d   = narrow_d[DW-1] ? '0 : narrow_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      j_q        <= '0;
      hk_q       <= '0;
      k_q        <= '0;
      mac_v_q    <= 1'b0;
      x_base_q   <= '0;
      w_base_q   <= '0;
      acc_q      <= '0;
      for (int i = 0; i < HIDDEN; i++) hid_q[i] <= '0;
      x_addr_q   <= '0;
      w_addr_q   <= '0;
      out_we_q   <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q  <= S_HMAC;
            busy_q   <= 1'b1;
            row_q    <= '0;
            j_q      <= '0;
            k_q      <= '0;
            mac_v_q  <= 1'b0;
            x_base_q <= '0;
            w_base_q <= '0;
            x_addr_q <= '0;
            w_addr_q <= '0;
            acc_q    <= '0;
          end
        end
        // ROM data lags the address by one cycle, so the MAC consumes the previous read.
        S_HMAC: begin
          if (mac_v_q) acc_q <= acc_q + AW'(prod_d);
          mac_v_q <= (k_q != KW'(COLUMNS));
          if (k_q < KW'(COLUMNS-1)) begin
            k_q      <= k_q + KW'(1);
            x_addr_q <= x_addr_q + XAW'(1);
            w_addr_q <= w_addr_q + WAW'(1);
          end else if (k_q == KW'(COLUMNS-1)) begin
            k_q      <= k_q + KW'(1);
            w_addr_q <= WAW'(HIDDEN*COLUMNS) + WAW'(j_q);
          end else begin
            state_q  <= S_HBIAS;
          end
        end
        S_HBIAS: begin
          hid_q[j_q] <= relu_d;
          acc_q      <= '0;
          k_q        <= '0;
          mac_v_q    <= 1'b0;
          if (j_q != JW'(HIDDEN-1)) begin
            j_q      <= j_q + JW'(1);
            x_addr_q <= x_base_q;
            w_base_q <= w_base_q + WAW'(COLUMNS);
            w_addr_q <= w_base_q + WAW'(COLUMNS);
            state_q  <= S_HMAC;
          end else begin
            j_q      <= '0;
            w_base_q <= '0;
            w_addr_q <= WAW'(HIDDEN*(COLUMNS+1));
            state_q  <= S_OMAC;
          end
        end
        // w2[] and b2 are contiguous, so the address simply walks forward.
        S_OMAC: begin
          if (mac_v_q) acc_q <= acc_q + AW'(prod_d);
          mac_v_q <= (k_q != KW'(HIDDEN));
          hk_q    <= JW'(k_q);
          if (k_q != KW'(HIDDEN)) begin
            k_q      <= k_q + KW'(1);
            w_addr_q <= w_addr_q + WAW'(1);
          end else begin
            k_q      <= '0;
            state_q  <= S_OBIAS;
          end
        end
        S_OBIAS: begin
          out_data_q <= narrow_d;
          out_addr_q <= row_q;
          out_we_q   <= 1'b1;
          acc_q      <= '0;
          state_q    <= S_WRITE;
        end
        S_WRITE: begin
          out_we_q   <= 1'b0;
          out_data_q <= '0;
          out_addr_q <= '0;
          w_addr_q   <= '0;
          w_base_q   <= '0;
          if (row_q != OAW'(ROWS-1)) begin
            row_q    <= row_q + OAW'(1);
            x_base_q <= x_base_q + XAW'(COLUMNS);
            x_addr_q <= x_base_q + XAW'(COLUMNS);
            state_q  <= S_HMAC;
          end else begin
            row_q    <= '0;
            x_base_q <= '0;
            x_addr_q <= '0;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign x_addr   = x_addr_q;
  assign w_addr   = w_addr_q;
  assign out_we   = out_we_q;
  assign out_addr = out_addr_q;
  assign out_data = out_data_q;
  assign busy     = busy_q;
  assign done_fp  = done_q;

endmodule

// File: tb/tb_fwd_prop_engine.sv
// tb/tb_fwd_prop_engine.sv - directed-vector bench for fwd_prop_engine with ROM models
module tb_fwd_prop_engine;
  localparam int ROWS    = 100;
  localparam int COLUMNS = 15;
  localparam int HIDDEN  = 10;
  localparam int WN      = HIDDEN*(COLUMNS+2)+1;
  localparam int ROW_T   = 183;
`ifdef FP_SATURATE_EN
  localparam logic [15:0] EXP_ONES = 16'h7FFF;
`else
  localparam logic [15:0] EXP_ONES = 16'h9600;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [10:0]        x_addr;
  logic signed [15:0] x_data = '0;
  logic [7:0]         w_addr;
  logic signed [15:0] w_data = '0;
  logic               out_we;
  logic [6:0]         out_addr;
  logic signed [15:0] out_data;
  logic               busy;
  logic               done_fp;

  logic [15:0] x_rom [ROWS*COLUMNS];
  logic [15:0] w_rom [WN];

  int nvec = 0;
  int nfail = 0;
  int we_cyc[$];
  int we_addr[$];
  logic [15:0] we_data[$];
  int done_cnt, done_cyc, busy_at_done, busy_pre, busy_post, timed_out;

  fwd_prop_engine dut (
    .clk(clk), .rst(rst), .start(start),
    .x_addr(x_addr), .x_data(x_data),
    .w_addr(w_addr), .w_data(w_data),
    .out_we(out_we), .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done_fp(done_fp)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    x_data <= x_rom[x_addr];
    w_data <= w_rom[w_addr];
  end

  task automatic load_rom(input logic [15:0] xe, input logic [15:0] xo, input logic [15:0] w1,
                          input logic [15:0] b1, input logic [15:0] w2, input logic [15:0] b2);
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < COLUMNS; k++)
        x_rom[r*COLUMNS+k] = (r % 2 == 1) ? xo : xe;
    for (int i = 0; i < HIDDEN*COLUMNS; i++) w_rom[i] = w1;
    for (int j = 0; j < HIDDEN; j++) begin
      w_rom[HIDDEN*COLUMNS+j]     = b1;
      w_rom[HIDDEN*(COLUMNS+1)+j] = w2;
    end
    w_rom[HIDDEN*(COLUMNS+2)] = b2;
  endtask

  // Pulses start and records every write strobe and done pulse with its cycle offset.
  task automatic run_collect(input int start2_at);
    int cyc;
    we_cyc.delete(); we_addr.delete(); we_data.delete();
    done_cnt = 0; done_cyc = -1; busy_at_done = -1; timed_out = 0;
    @(negedge clk);
    busy_pre = int'(busy);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    busy_post = int'(busy);
    while (done_cnt == 0 && cyc < 20000) begin
      start = (cyc + 1 == start2_at);
      @(posedge clk); #1;
      cyc++;
      if (out_we) begin
        we_cyc.push_back(cyc); we_addr.push_back(int'(out_addr)); we_data.push_back(out_data);
      end
      if (done_fp) begin
        done_cnt++; done_cyc = cyc; busy_at_done = int'(busy);
      end
    end
    start = 1'b0;
    timed_out = (done_cnt == 0) ? 1 : 0;
    repeat (4) begin
      @(posedge clk); #1;
      cyc++;
      if (done_fp) done_cnt++;
      if (out_we) begin
        we_cyc.push_back(cyc); we_addr.push_back(int'(out_addr)); we_data.push_back(out_data);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if ({out_we, busy, done_fp} !== 3'b000) begin
      nfail++; $display("FAIL reset_ctrl: got we/busy/done=%b required 000", {out_we, busy, done_fp});
    end
    nvec++;
    if ({x_addr, w_addr, out_addr, out_data} !== '0) begin
      nfail++; $display("FAIL reset_data: got x=%h w=%h oa=%h od=%h required all 0", x_addr, w_addr, out_addr, out_data);
    end
    for (int j = 0; j < HIDDEN; j++) begin
      nvec++;
      if (dut.hid_q[j] !== 16'h0000) begin
        nfail++; $display("FAIL reset_hid[%0d]: got %h required 0000", j, dut.hid_q[j]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_all_ones();
    load_rom(16'h0100, 16'h0100, 16'h0100, 16'h0000, 16'h0100, 16'h0000);
    run_collect(50);
    nvec++;
    if (busy_pre !== 0 || busy_post !== 1) begin
      nfail++; $display("FAIL busy_rise: got pre=%0d post=%0d required 0 1", busy_pre, busy_post);
    end
    nvec++;
    if (timed_out !== 0) begin
      nfail++; $display("FAIL done_timeout: got no done_fp required done within budget");
    end
    nvec++;
    if (done_cyc !== ROWS*ROW_T+1) begin
      nfail++; $display("FAIL done_cycle: got %0d required %0d", done_cyc, ROWS*ROW_T+1);
    end
    nvec++;
    if (done_cnt !== 1 || busy_at_done !== 0) begin
      nfail++; $display("FAIL done_pulse: got width=%0d busy=%0d required 1 0", done_cnt, busy_at_done);
    end
    nvec++;
    if (we_cyc.size() !== ROWS) begin
      nfail++; $display("FAIL we_count: got %0d required %0d", we_cyc.size(), ROWS);
    end
    for (int i = 0; i < we_cyc.size() && i < ROWS; i++) begin
      nvec++;
      if (we_addr[i] !== i || we_cyc[i] !== ROW_T*(i+1)-1 || we_data[i] !== EXP_ONES) begin
        nfail++;
        $display("FAIL ones_row%0d: got addr=%0d cyc=%0d data=%h required %0d %0d %h",
                 i, we_addr[i], we_cyc[i], we_data[i], i, ROW_T*(i+1)-1, EXP_ONES);
      end
    end
    for (int j = 0; j < HIDDEN; j++) begin
      nvec++;
      if (dut.hid_q[j] !== 16'h0F00) begin
        nfail++; $display("FAIL ones_hid[%0d]: got %h required 0f00", j, dut.hid_q[j]);
      end
    end
  endtask

  task automatic test_reset_midrun();
    int seen_we, seen_done, seen_busy;
    load_rom(16'h0100, 16'h0100, 16'h0080, 16'hF800, 16'h0100, 16'h0200);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (1000) @(posedge clk);
    #3;
    nvec++;
    if (busy !== 1'b1) begin
      nfail++; $display("FAIL midrun_busy: got %b required 1", busy);
    end
    rst = 1'b1;
    #1;
    nvec++;
    if ({out_we, busy, done_fp, x_addr, w_addr, out_addr, out_data} !== '0) begin
      nfail++;
      $display("FAIL async_reset: got we=%b busy=%b done=%b x=%h w=%h oa=%h od=%h required all 0",
               out_we, busy, done_fp, x_addr, w_addr, out_addr, out_data);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen_we = 0; seen_done = 0; seen_busy = 0;
    repeat (400) begin
      @(posedge clk); #1;
      if (out_we) seen_we++;
      if (done_fp) seen_done++;
      if (busy) seen_busy++;
    end
    nvec++;
    if (seen_we !== 0 || seen_done !== 0 || seen_busy !== 0) begin
      nfail++; $display("FAIL post_abort: got we=%0d done=%0d busy=%0d required 0 0 0", seen_we, seen_done, seen_busy);
    end
  endtask

  task automatic test_relu_clip();
    load_rom(16'h0100, 16'h0100, 16'h0080, 16'hF800, 16'h0100, 16'h0200);
    run_collect(-1);
    nvec++;
    if (timed_out !== 0 || done_cyc !== ROWS*ROW_T+1 || done_cnt !== 1) begin
      nfail++; $display("FAIL relu_done: got cyc=%0d width=%0d required %0d 1", done_cyc, done_cnt, ROWS*ROW_T+1);
    end
    nvec++;
    if (we_cyc.size() !== ROWS) begin
      nfail++; $display("FAIL relu_count: got %0d required %0d", we_cyc.size(), ROWS);
    end
    for (int i = 0; i < we_cyc.size() && i < ROWS; i++) begin
      nvec++;
      if (we_addr[i] !== i || we_data[i] !== 16'h0200) begin
        nfail++; $display("FAIL relu_row%0d: got addr=%0d data=%h required %0d 0200", i, we_addr[i], we_data[i], i);
      end
    end
    for (int j = 0; j < HIDDEN; j++) begin
      nvec++;
      if (dut.hid_q[j] !== 16'h0000) begin
        nfail++; $display("FAIL relu_hid[%0d]: got %h required 0000", j, dut.hid_q[j]);
      end
    end
  endtask

  // Even rows x=0.5 -> y=-18.75; odd rows x=0.25 -> h=0.9375, y=-9.375.
  task automatic test_signed_neg();
    logic [15:0] exp_y;
    load_rom(16'h0080, 16'h0040, 16'h0040, 16'h0000, 16'hFF00, 16'h0000);
    run_collect(-1);
    nvec++;
    if (timed_out !== 0 || done_cyc !== ROWS*ROW_T+1) begin
      nfail++; $display("FAIL neg_done: got cyc=%0d required %0d", done_cyc, ROWS*ROW_T+1);
    end
    nvec++;
    if (we_cyc.size() !== ROWS) begin
      nfail++; $display("FAIL neg_count: got %0d required %0d", we_cyc.size(), ROWS);
    end
    for (int i = 0; i < we_cyc.size() && i < ROWS; i++) begin
      exp_y = (i % 2 == 1) ? 16'hF6A0 : 16'hED40;
      nvec++;
      if (we_addr[i] !== i || we_data[i] !== exp_y) begin
        nfail++; $display("FAIL neg_row%0d: got addr=%0d data=%h required %0d %h", i, we_addr[i], we_data[i], i, exp_y);
      end
    end
    for (int j = 0; j < HIDDEN; j++) begin
      nvec++;
      if (dut.hid_q[j] !== 16'h00F0) begin
        nfail++; $display("FAIL neg_hid[%0d]: got %h required 00f0", j, dut.hid_q[j]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_reset_midrun();
    test_relu_clip();
    test_signed_neg();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
